// File: rtl/nv_nvdla_sdp_core_y_cvt_chn_in_rsci_rcv_pkg.sv
// Shared SDP Y-cvt definitions: default channel word width and skid-buffer occupancy type.
package nv_nvdla_sdp_core_y_cvt_chn_in_rsci_rcv_pkg;

  localparam int SDP_DATA_W = 32;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_EMPTY = 2'd0;
  localparam cnt_t CNT_ONE   = 2'd1;
  localparam cnt_t CNT_FULL  = 2'd2;

endpackage

// File: rtl/nv_nvdla_sdp_core_y_cvt_chn_in_rsci_rcv_skid2.sv
// Generic 2-entry register FIFO; the caller must never push when full or pop when empty.
module nv_nvdla_sdp_core_y_cvt_skid2
  import nv_nvdla_sdp_core_y_cvt_chn_in_rsci_rcv_pkg::*;
#(
  parameter int W = SDP_DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output cnt_t         cnt
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic         hd;
  logic         wr_idx;

  // With one word resident the free slot is the one after the head.
  assign wr_idx = hd ^ (cnt == CNT_ONE);
  assign dout   = hd ? ent1 : ent0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      hd   <= 1'b0;
      cnt  <= CNT_EMPTY;
    end else begin
      if (push) begin
        if (wr_idx) ent1 <= din;
        else        ent0 <= din;
      end
      if (pop) hd <= ~hd;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/nv_nvdla_sdp_core_y_cvt_chn_in_rsci_rcv.sv
// chn_in receive interface: upstream valid/ready into a 2-entry skid buffer, read by the core's stall-wait handshake.
module nv_nvdla_sdp_core_y_cvt_chn_in_rsci_rcv
  import nv_nvdla_sdp_core_y_cvt_chn_in_rsci_rcv_pkg::*;
#(
  parameter int DATA_W = SDP_DATA_W
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              chn_in_rsc_vz,
  input  logic [DATA_W-1:0] chn_in_rsc_z,
  output logic              chn_in_rsc_lz,
  input  logic              chn_in_rsci_oswt,
  input  logic              chn_in_rsci_bdwt,
  output logic              chn_in_rsci_bawt,
  output logic              chn_in_rsci_wen_comp,
  output logic [DATA_W-1:0] chn_in_rsci_d_mxwt
);

  cnt_t cnt;
  logic push;
  logic pop;

  // Ready and available depend only on registered occupancy, so vz/bdwt never reach an output.
  assign chn_in_rsc_lz        = (cnt != CNT_FULL);
  assign chn_in_rsci_bawt     = (cnt != CNT_EMPTY);
  assign chn_in_rsci_wen_comp = ~chn_in_rsci_oswt | chn_in_rsci_bawt;

  assign push = chn_in_rsc_vz & chn_in_rsc_lz;
  assign pop  = chn_in_rsci_oswt & chn_in_rsci_bdwt & chn_in_rsci_bawt;

  nv_nvdla_sdp_core_y_cvt_skid2 #(
    .W (DATA_W)
  ) u_skid (
    .clk   (nvdla_core_clk),
    .rst_n (nvdla_core_rstn),
    .push  (push),
    .pop   (pop),
    .din   (chn_in_rsc_z),
    .dout  (chn_in_rsci_d_mxwt),
    .cnt   (cnt)
  );

endmodule

// File: tb/tb_nv_nvdla_sdp_core_y_cvt_chn_in_rsci_rcv.sv
// Bench: directed scenarios plus random traffic, checked every cycle against a queue model of the buffer.
module tb_nv_nvdla_sdp_core_y_cvt_chn_in_rsci_rcv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vz = 1'b0;
  logic [31:0] z = '0;
  logic        lz;
  logic        oswt = 1'b0;
  logic        bdwt = 1'b0;
  logic        bawt;
  logic        wen_comp;
  logic [31:0] d_mxwt;

  int checks = 0;
  int failures = 0;

  logic [31:0] q[$];

  always #5 clk = ~clk;

  nv_nvdla_sdp_core_y_cvt_chn_in_rsci_rcv #(.DATA_W(32)) dut (
    .nvdla_core_clk       (clk),
    .nvdla_core_rstn      (rst_n),
    .chn_in_rsc_vz        (vz),
    .chn_in_rsc_z         (z),
    .chn_in_rsc_lz        (lz),
    .chn_in_rsci_oswt     (oswt),
    .chn_in_rsci_bdwt     (bdwt),
    .chn_in_rsci_bawt     (bawt),
    .chn_in_rsci_wen_comp (wen_comp),
    .chn_in_rsci_d_mxwt   (d_mxwt)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  // Reference: the buffer is just an ordered queue of at most two words.
  always @(negedge rst_n) q.delete();

  always @(posedge clk) begin
    bit do_push;
    bit do_pop;
    if (rst_n) begin
      do_push = vz && (q.size() < 2);
      do_pop  = oswt && bdwt && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(z);
    end
  end

  always @(negedge clk) begin
    cmp("lz", {31'd0, lz}, {31'd0, q.size() != 2});
    cmp("bawt", {31'd0, bawt}, {31'd0, q.size() != 0});
    cmp("wen_comp", {31'd0, wen_comp}, {31'd0, !oswt || q.size() != 0});
    if (!rst_n) cmp("d_mxwt_rst", d_mxwt, 32'h0);
    else if (q.size() > 0) cmp("d_mxwt", d_mxwt, q[0]);
  end

  task automatic step(input logic v, input logic [31:0] d, input logic o, input logic b);
    vz = v; z = d; oswt = o; bdwt = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a pending read request.
    oswt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_lz", {31'd0, lz}, 32'd1);
    cmp("rst_bawt", {31'd0, bawt}, 32'd0);
    cmp("rst_wen_comp", {31'd0, wen_comp}, 32'd0);
    cmp("rst_d", d_mxwt, 32'h0);
    rst_n = 1'b1;

    step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    cmp("first_bawt", {31'd0, bawt}, 32'd1);
    cmp("first_d", d_mxwt, 32'hA5A5_0001);
    oswt = 1'b1; #1;
    cmp("first_wen", {31'd0, wen_comp}, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    cmp("first_drained", {31'd0, bawt}, 32'd0);

    // Fill to full, third word held upstream, then drain in order.
    step(1'b1, 32'h1, 1'b0, 1'b0);
    cmp("fill1_lz", {31'd0, lz}, 32'd1);
    step(1'b1, 32'h2, 1'b0, 1'b0);
    cmp("full_lz", {31'd0, lz}, 32'd0);
    step(1'b1, 32'h3, 1'b0, 1'b0);
    cmp("full_hold_d", d_mxwt, 32'h1);
    step(1'b1, 32'h3, 1'b1, 1'b1);
    cmp("pop1_lz", {31'd0, lz}, 32'd1);
    cmp("pop1_d", d_mxwt, 32'h2);
    step(1'b1, 32'h3, 1'b1, 1'b1);
    cmp("pop2_d", d_mxwt, 32'h3);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    cmp("pop3_empty", {31'd0, bawt}, 32'd0);

    // Core stall with bdwt low.
    step(1'b1, 32'h55, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      cmp("stall_wen", {31'd0, wen_comp}, 32'd1);
      cmp("stall_d", d_mxwt, 32'h55);
      cmp("stall_bawt", {31'd0, bawt}, 32'd1);
    end
    step(1'b0, 32'h0, 1'b1, 1'b1);
    cmp("stall_release", {31'd0, bawt}, 32'd0);

    // Streaming at one word per cycle.
    step(1'b1, 32'd100, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cmp("stream_d", d_mxwt, 32'd100 + 32'(i));
      step(1'b1, 32'd101 + 32'(i), 1'b1, 1'b1);
      cmp("stream_lz", {31'd0, lz}, 32'd1);
    end
    step(1'b0, 32'h0, 1'b1, 1'b1);

    // Empty read, then a word arrives.
    step(1'b0, 32'h0, 1'b1, 1'b1);
    cmp("empty_wen", {31'd0, wen_comp}, 32'd0);
    cmp("empty_bawt", {31'd0, bawt}, 32'd0);
    step(1'b1, 32'hBEEF, 1'b1, 1'b1);
    cmp("beef_wen", {31'd0, wen_comp}, 32'd1);
    cmp("beef_d", d_mxwt, 32'hBEEF);
    step(1'b0, 32'h0, 1'b1, 1'b1);

    // Asynchronous reset while full.
    step(1'b1, 32'h7, 1'b0, 1'b0);
    step(1'b1, 32'h8, 1'b0, 1'b0);
    cmp("pre_rst_lz", {31'd0, lz}, 32'd0);
    vz = 1'b0; oswt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    cmp("mid_rst_lz", {31'd0, lz}, 32'd1);
    cmp("mid_rst_bawt", {31'd0, bawt}, 32'd0);
    cmp("mid_rst_d", d_mxwt, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 32'hCAFE, 1'b0, 1'b0);
    cmp("post_rst_d", d_mxwt, 32'hCAFE);
    step(1'b0, 32'h0, 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    step(1'b0, 32'h0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
